// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if
// Groups the byte-interface handshake and the register bus of spi_reg_ctrl.
//   SS         raw SPI slave select (active low)
//   rxValid    1-cycle pulse: rx holds a new byte
//   rx         received byte
//   tx         byte to transmit next
//   reg_addr   register bus address
//   reg_wdata  register bus write data
//   reg_we     1-cycle write strobe
//   reg_re     1-cycle read strobe (reg_rdata valid the following cycle)
//   reg_rdata  register bus read data
//   busy       frame in progress
//   frame_done 1-cycle pulse at frame end
//   addr_err   sticky out-of-range flag, cleared at frame start
// modport master: the sequencer side; modport slave: byte interface + register file side.
interface spi_reg_ctrl_if;
  logic       SS;
  logic       rxValid;
  logic [7:0] rx;
  logic [7:0] tx;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_done;
  logic       addr_err;

  modport master (
    input  SS, rxValid, rx, reg_rdata,
    output tx, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done, addr_err
  );

  modport slave (
    output SS, rxValid, rx, reg_rdata,
    input  tx, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done, addr_err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Byte-level command sequencer above an SPI mode-3 byte slave. The first byte
// of each SS frame is {RW, ADDR[6:0]}; following bytes are written to, or read
// from, the register bus with address auto-increment. Read data is placed on tx
// three cycles after the triggering byte so it is ready for the next byte.
// Ports:
//   sysClk    system clock, rising edge
//   usrReset  asynchronous active-high reset
//   bus       spi_reg_ctrl_if.master (byte interface + register bus)
module spi_reg_ctrl #(
  parameter int         NUM_REGS    = 128,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic                  sysClk,
  input  logic                  usrReset,
  spi_reg_ctrl_if.master        bus
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD_ISSUE, RD_LOAD, RD} state_t;

  state_t     state_q, state_d;

  logic       ss_p0, ss_p1, ss_p2;
  logic       frame_start, frame_end;

  logic [7:0] tx_q;
  logic [6:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       wr_inc_q;
  logic       busy_q;
  logic       frame_done_q;
  logic       addr_err_q;

  logic       in_range;
  logic       re_c, ld_cmd, wr_acc, rd_load, err_set;

  assign in_range = ({25'd0, reg_addr_q} < NUM_REGS);

  // SS synchronizer: ss_p1 is the synchronized level, ss_p2 its previous value.
  // The flops reset low so a reset taken mid-frame (SS still low) does not
  // produce a fresh frame start; the resulting low->high edge when SS is idle
  // is harmless because frame end is only acted on outside IDLE.
  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      ss_p0 <= 1'b0;
      ss_p1 <= 1'b0;
      ss_p2 <= 1'b0;
    end else begin
      ss_p0 <= bus.SS;
      ss_p1 <= ss_p0;
      ss_p2 <= ss_p1;
    end
  end

  assign frame_start = ss_p2 & ~ss_p1;
  assign frame_end   = ~ss_p2 & ss_p1 & (state_q != IDLE);

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Frame end wins over everything (including a coincident rxValid), then a
  // frame start restarts at CMD from whatever state we were in.
  always_comb begin
    state_d = state_q;
    re_c    = 1'b0;
    ld_cmd  = 1'b0;
    wr_acc  = 1'b0;
    rd_load = 1'b0;
    err_set = 1'b0;
    if (frame_end) begin
      state_d = IDLE;
    end else if (frame_start) begin
      state_d = CMD;
    end else begin
      case (state_q)
        CMD: begin
          if (bus.rxValid) begin
            ld_cmd  = 1'b1;
            state_d = bus.rx[7] ? RD_ISSUE : WR;
          end
        end
        WR: begin
          if (bus.rxValid) begin
            wr_acc  = 1'b1;
            err_set = ~in_range;
          end
        end
        RD_ISSUE: begin
          re_c    = in_range;
          err_set = ~in_range;
          state_d = RD_LOAD;
        end
        RD_LOAD: begin
          rd_load = 1'b1;
          state_d = RD;
        end
        RD: begin
          if (bus.rxValid) state_d = RD_ISSUE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output / datapath registers. The write strobe is registered so it lines up
  // with reg_wdata; the address advances one cycle after the strobe.
  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      tx_q         <= STATUS_BYTE;
      reg_addr_q   <= 7'd0;
      reg_wdata_q  <= 8'd0;
      reg_we_q     <= 1'b0;
      wr_inc_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      reg_we_q     <= wr_acc & in_range;
      wr_inc_q     <= wr_acc;

      if (frame_end)        busy_q <= 1'b0;
      else if (frame_start) busy_q <= 1'b1;

      if (frame_start)  addr_err_q <= 1'b0;
      else if (err_set) addr_err_q <= 1'b1;

      if (frame_end || frame_start) tx_q <= STATUS_BYTE;
      else if (rd_load)             tx_q <= in_range ? bus.reg_rdata : 8'h00;

      if (wr_acc) reg_wdata_q <= bus.rx;

      if (ld_cmd)                   reg_addr_q <= bus.rx[6:0];
      else if (wr_inc_q || rd_load) reg_addr_q <= reg_addr_q + 7'd1;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_re     = re_c;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.addr_err   = addr_err_q;

endmodule
